if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the MIPS pipeline: owns the PC, runs a req/ack handshake to instruction memory, and presents a registered IF/ID bundle (valid, pc, pc+4, instr) to decode.
- Handles decode stall and branch/jump redirect (flush).
- Provides a one-entry skid buffer so data returned during a stall is never lost.

---
 rtl/mips_pkg.sv | 14 +
 rtl/if_skid_buf.sv | 40 ++++
 rtl/if_fetch_stage.sv | 138 +++++++++++++
 tb/tb_if_fetch_stage.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants for the MIPS pipeline front end.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int unsigned PC_INC    = 4;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {pc, instr} holding register; captures a fetch that returns while decode is stalled.
// Load/clear take effect on the next edge; clear wins, so a flushed entry can never resurface.
module if_skid_buf
    import mips_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          clear_i,
    input  logic [AW-1:0] pc_i,
    input  logic [DW-1:0] instr_i,
    output logic          valid_o,
    output logic [AW-1:0] pc_o,
    output logic [DW-1:0] instr_o
);

    logic          valid_q;
    logic [AW-1:0] pc_q;
    logic [DW-1:0] instr_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= DW'(NOP_INSTR);
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            instr_q <= instr_i;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, handshakes with imem, presents a registered IF/ID bundle.
// ack in cycle n appears on if_* in n+1; stall holds if_* and parks one late fetch in the skid.
module if_fetch_stage
    import mips_pkg::*;
#(
    parameter int          AW       = 32,
    parameter int          DW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [DW-1:0] imem_rdata,
    input  logic          stall,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic          if_valid,
    output logic [AW-1:0] if_pc,
    output logic [AW-1:0] if_pc4,
    output logic [DW-1:0] if_instr
);

    fetch_state_e  state_q;
    logic [AW-1:0] pc_q;
    logic          req_q;
    logic [AW-1:0] addr_q;
    logic          valid_q;
    logic [AW-1:0] ifpc_q;
    logic [AW-1:0] ifpc4_q;
    logic [DW-1:0] instr_q;

    logic          skid_load;
    logic          skid_clear;
    logic          skid_vld;
    logic [AW-1:0] skid_pc;
    logic [DW-1:0] skid_instr;
    logic [AW-1:0] pc_inc;

    assign pc_inc = pc_q + AW'(PC_INC);

    always_comb begin
        skid_load  = (state_q == ST_REQ) && !redirect && imem_ack && valid_q && stall;
        skid_clear = (state_q == ST_HOLD) && (redirect || !stall);
    end

    if_skid_buf #(.AW(AW), .DW(DW)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .pc_i    (pc_q),
        .instr_i (imem_rdata),
        .valid_o (skid_vld),
        .pc_o    (skid_pc),
        .instr_o (skid_instr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            ifpc_q  <= '0;
            ifpc4_q <= '0;
            instr_q <= DW'(NOP_INSTR);
        end else begin
            // Redirect flushes the bundle unconditionally; the case below only steers imem.
            if (redirect) begin
                valid_q <= 1'b0;
                instr_q <= DW'(NOP_INSTR);
                pc_q    <= redirect_pc;
            end
            case (state_q)
                ST_IDLE: begin
                    req_q   <= 1'b1;
                    addr_q  <= redirect ? redirect_pc : pc_q;
                    state_q <= ST_REQ;
                end
                ST_REQ: begin
                    if (redirect) begin
                        if (imem_ack) addr_q  <= redirect_pc;
                        else          state_q <= ST_DRAIN;
                    end else if (imem_ack) begin
                        pc_q <= pc_inc;
                        if (!valid_q || !stall) begin
                            valid_q <= 1'b1;
                            ifpc_q  <= pc_q;
                            ifpc4_q <= pc_inc;
                            instr_q <= imem_rdata;
                            addr_q  <= pc_inc;
                        end else begin
                            req_q   <= 1'b0;
                            state_q <= ST_HOLD;
                        end
                    end else if (!stall) begin
                        valid_q <= 1'b0;
                        instr_q <= DW'(NOP_INSTR);
                    end
                end
                ST_HOLD: begin
                    if (redirect) begin
                        req_q   <= 1'b1;
                        addr_q  <= redirect_pc;
                        state_q <= ST_REQ;
                    end else if (!stall && skid_vld) begin
                        valid_q <= 1'b1;
                        ifpc_q  <= skid_pc;
                        ifpc4_q <= skid_pc + AW'(PC_INC);
                        instr_q <= skid_instr;
                        req_q   <= 1'b1;
                        addr_q  <= pc_q;
                        state_q <= ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    // The in-flight request could not be withdrawn; its data is dropped here.
                    if (imem_ack) begin
                        addr_q  <= redirect ? redirect_pc : pc_q;
                        state_q <= ST_REQ;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign if_valid  = valid_q;
    assign if_pc     = ifpc_q;
    assign if_pc4    = ifpc4_q;
    assign if_instr  = instr_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized bench: program-order scoreboard of consumed IF/ID bundles plus handshake/hold checks.
module tb_if_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic [31:0] if_instr;

    int checks = 0;
    int errors = 0;
    int consumed = 0;
    int wrap_seen = 0;
    int wait_cnt = 0;
    int maxw = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    if_fetch_stage #(.AW(32), .DW(32), .RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_pc4      (if_pc4),
        .if_instr    (if_instr)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Decode should next see the instruction at 'start' and then sequential words after it.
    task automatic restart_stream(input logic [31:0] start);
        exp_q.delete();
        exp_q.push_back(start);
    endtask

    task automatic cycle(input int stall_pct, input int redir_pct,
                         input bit force_r = 1'b0, input logic [31:0] fpc = '0);
        @(posedge clk);
        #1;
        imem_rdata = mem_word(imem_addr);
        if (rst) begin
            imem_ack = 1'b0;
            wait_cnt = 0;
        end else if (!imem_req) begin
            imem_ack = 1'b0;
        end else if (wait_cnt == 0) begin
            imem_ack = 1'b1;
            wait_cnt = int'($urandom_range(0, maxw));
        end else begin
            imem_ack = 1'b0;
            wait_cnt--;
        end
        stall    = (int'($urandom_range(0, 99)) < stall_pct);
        redirect = force_r || (int'($urandom_range(0, 99)) < redir_pct);
        if (redirect) begin
            redirect_pc = force_r ? fpc : ($urandom & 32'h0000_0FFC);
            restart_stream(redirect_pc);
        end
    endtask

    // Monitor: samples at negedge, i.e. exactly what the next rising edge will act on.
    logic        prev_pending = 1'b0;
    logic [31:0] prev_addr = '0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_pc = '0;
    logic [31:0] prev_pc4 = '0;
    logic [31:0] prev_instr = '0;

    always @(negedge clk) begin
        if (prev_pending) begin
            chk("imem_req held until ack", {31'b0, imem_req}, 32'd1);
            chk("imem_addr stable while pending", imem_addr, prev_addr);
        end
        if (prev_hold) begin
            chk("stall hold if_valid", {31'b0, if_valid}, 32'd1);
            chk("stall hold if_pc", if_pc, prev_pc);
            chk("stall hold if_pc4", if_pc4, prev_pc4);
            chk("stall hold if_instr", if_instr, prev_instr);
        end
        if (!rst && !if_valid)
            chk("if_instr NOP when invalid", if_instr, 32'h0);
        if (!rst && if_valid && !stall && !redirect) begin
            consumed++;
            if (exp_q.size() == 0) begin
                chk("scoreboard empty on consume", 32'd1, 32'd0);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("if_pc order", if_pc, e);
                chk("if_pc4", if_pc4, e + 32'd4);
                chk("if_instr", if_instr, mem_word(e));
                if (e == 32'hFFFF_FFFC) wrap_seen++;
                if (exp_q.size() == 0) exp_q.push_back(e + 32'd4);
            end
        end
        prev_pending = !rst && imem_req && !imem_ack;
        prev_addr    = imem_addr;
        prev_hold    = !rst && if_valid && stall && !redirect;
        prev_pc      = if_pc;
        prev_pc4     = if_pc4;
        prev_instr   = if_instr;
    end

    initial begin
        int c0;
        rst = 1'b1;
        maxw = 0;
        restart_stream(RST_PC);
        repeat (2) cycle(0, 0);
        chk("reset imem_req", {31'b0, imem_req}, 32'd0);
        chk("reset imem_addr", imem_addr, 32'h0);
        chk("reset if_valid", {31'b0, if_valid}, 32'd0);
        chk("reset if_pc", if_pc, 32'h0);
        chk("reset if_pc4", if_pc4, 32'h0);
        chk("reset if_instr", if_instr, 32'h0);
        rst = 1'b0;
        cycle(0, 0);
        chk("first imem_req after reset", {31'b0, imem_req}, 32'd1);
        chk("first imem_addr after reset", imem_addr, RST_PC);

        repeat (12) cycle(0, 0);

        maxw = 2;
        repeat (300) cycle(30, 0);

        maxw = 3;
        repeat (600) cycle(25, 5);

        maxw = 0;
        cycle(0, 0, 1'b1, 32'h0000_0200);
        repeat (10) cycle(0, 0);
        c0 = consumed;
        repeat (20) cycle(0, 0);
        chk("zero-wait throughput", 32'(consumed - c0), 32'd20);

        cycle(0, 0, 1'b1, 32'hFFFF_FFF8);
        repeat (8) cycle(0, 0);
        chk("wrap FFFFFFFC delivered", 32'(wrap_seen > 0), 32'd1);

        rst = 1'b1;
        repeat (2) cycle(0, 0);
        restart_stream(RST_PC);
        rst = 1'b0;
        cycle(0, 0);
        chk("imem_addr after mid-run reset", imem_addr, RST_PC);

        maxw = 3;
        repeat (300) cycle(20, 3);

        maxw = 0;
        c0 = consumed;
        repeat (20) cycle(0, 0);
        chk("progress after drain", 32'(consumed > c0 + 10), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
